dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the far end of the MEM-stage data access interface.
- Accepts one load/store request at a time: address from Aluout, store data from busB, size codes from MemRead/MemWrite.
- Performs the access on internal byte-enabled word storage after a configurable number of wait states.
- Returns aligned, extended load data with a valid pulse and holds the pipeline via stall while busy.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; power of two.
- WAIT_STATES, 1, extra cycles between accept and access; 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- MemRead  in  2  load size: 00 none, 01 byte, 10 half, 11 word.
- MemWrite  in  2  store size, same encoding as MemRead.
- mem_unsigned  in  1  1 = zero-extend load data, 0 = sign-extend.
- Aluout  in  32  byte address.
- busB  in  32  store data, right-justified.
- ready  out  1  high only in IDLE.
- stall  out  1  high while a request is in flight: any state except IDLE.
- resp_valid  out  1  one-cycle response pulse.
- rdata  out  32  extended load data; valid while resp_valid is high.
- misalign  out  1  high with resp_valid when the request was misaligned.

Behaviour:
- Reset: all outputs 0 except ready=1; state IDLE; wait counter 0; captured request cleared. Storage contents are not reset.
- Reset mid-operation: returns to IDLE immediately. A store not yet in ACCESS is never committed.
- States:
  - IDLE: accept when req_valid & ready & (MemRead!=0 | MemWrite!=0). Latch address, size, data and unsigned flag. A request with both codes 00 is ignored.
  - After accept: misaligned goes to RESP; else WAIT_STATES>0 goes to WAIT with counter=WAIT_STATES; else goes to ACCESS.
  - WAIT: decrement counter each cycle; go to ACCESS when the counter reaches 1.
  - ACCESS: store commits at the end of this cycle; a load reads the word. Then RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. No request is accepted in RESP.
- Latency: accept in cycle 0 -> resp_valid in cycle WAIT_STATES+2. Back-to-back requests are spaced WAIT_STATES+3 cycles.
- Simultaneous MemRead and MemWrite nonzero: treated as a store of the MemWrite size; rdata=0.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A misaligned request returns misalign=1, rdata=0, and no write.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap.
- Store lanes:
  - byte: enable bit addr[1:0]; busB[7:0] replicated to all lanes.
  - half: enables 0011 or 1100 by addr[1]; busB[15:0] replicated.
  - word: enables 1111.
- Load: select the lane by addr[1:0], then zero- or sign-extend per mem_unsigned. For stores, rdata=0.
- rdata and misalign are 0 whenever resp_valid is 0.
- A store followed by a load to the same address returns the new data: no hazard window.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misalignment handling as above.
- Undefined: the low address bits below the access size are forced to 0; the access proceeds normally and misalign is tied to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - size constants SZ_NONE=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10, SZ_WORD=2'b11;
  - the state encoding IDLE/WAIT/ACCESS/RESP;
  - byte-enable generation and load-extension functions.
- One sub-module, dmem_ram: DEPTH_WORDS x 32 storage with 4-bit byte write enable and registered read.

Test Plan:
- WAIT_STATES=1; store word 0x12345678 @0x10; load word @0x10 -> resp_valid at cycle 3 after each accept, rdata=0x12345678, stall high cycles 1..3.
- Store byte 0xAB @0x21 over word 0 at 0x20; signed load byte @0x21 -> 0xFFFFFFAB; unsigned -> 0x000000AB; load word @0x20 -> 0x0000AB00.
- Signed load half @0x22 after storing half 0x8001 there -> 0xFFFF8001; load half @0x23 -> misalign=1, rdata=0, memory unchanged (trap enabled).
- Load word @(DEPTH_WORDS*4+0x10) -> same data as @0x10 (wrap).
- Reset asserted during WAIT of a store word 0xDEADBEEF @0x40 -> outputs 0, ready=1 immediately; later load @0x40 returns the prior contents.
- Both MemRead=11 and MemWrite=01 with busB=0x55 @0x8 -> byte 0x55 written, rdata=0; req_valid with both codes 00 -> no accept, ready stays 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states,
// and the lane helpers used for stores and loads.
package dmem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  // Byte write enables for a store of the given size at byte offset lo.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Pick the addressed lane out of a word and zero/sign extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_ext = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_ext = {{16{~uns & h[15]}}, h};
      SZ_WORD: load_ext = word;
      default: load_ext = 32'h0;
    endcase
  endfunction

  // True when the offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    misaligned = ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  // Clear the offset bits below the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: align_lo = {lo[1], 1'b0};
      SZ_WORD: align_lo = 2'b00;
      default: align_lo = lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word storage with per-byte write enables and a registered read port.
// Contents are intentionally not reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and read-before-write registered read on an enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, accesses dmem_ram, then pulses resp_valid with extended load data.
// Optional: DMEM_MISALIGN_TRAP_EN reports misaligned requests instead of
// silently aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic        mem_unsigned,
  input  logic [31:0] Aluout,
  input  logic [31:0] busB,
  output logic        ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, state_nxt;
  logic [3:0]    wcnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lo;
  logic [1:0]    r_size;
  logic          r_store, r_uns, r_mis;
  logic [31:0]   r_wdata;
  logic [31:0]   ram_q;
  logic [3:0]    ram_we;
  logic          ram_en;

  // A store wins when both codes are set; its size governs the access.
  logic       is_store_in;
  logic [1:0] size_in;
  logic       accept;
  logic       mis_in;
  logic [1:0] lo_in;

  assign is_store_in = (MemWrite != SZ_NONE);
  assign size_in     = is_store_in ? MemWrite : MemRead;
  assign accept      = ready && req_valid && (size_in != SZ_NONE);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in = misaligned(size_in, Aluout[1:0]);
  assign lo_in  = Aluout[1:0];
`else
  assign mis_in = 1'b0;
  assign lo_in  = align_lo(size_in, Aluout[1:0]);
`endif

  // Address bits above the storage index wrap and are not looked at.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Aluout[31:AW+2];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: misaligned requests skip straight to the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mis_in)               state_nxt = RESP;
          else if (WAIT_STATES > 0) state_nxt = WAIT;
          else                      state_nxt = ACCESS;
        end
      end
      WAIT:    if (wcnt <= 4'd1) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on accept and run the wait-state counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= 4'd0;
      r_idx   <= '0;
      r_lo    <= 2'b00;
      r_size  <= SZ_NONE;
      r_store <= 1'b0;
      r_uns   <= 1'b0;
      r_mis   <= 1'b0;
      r_wdata <= 32'h0;
    end else if (accept) begin
      wcnt    <= 4'(WAIT_STATES);
      r_idx   <= Aluout[AW+1:2];
      r_lo    <= lo_in;
      r_size  <= size_in;
      r_store <= is_store_in;
      r_uns   <= mem_unsigned;
      r_mis   <= mis_in;
      r_wdata <= store_data(size_in, busB);
    end else if (state == WAIT && wcnt != 4'd0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // The RAM is only touched in ACCESS, so an aborted store never lands.
  assign ram_en = (state == ACCESS);
  assign ram_we = (ram_en && r_store) ? byte_en(r_size, r_lo) : 4'b0000;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (r_idx),
    .wdata (r_wdata),
    .rdata (ram_q)
  );

  assign ready      = (state == IDLE);
  assign stall      = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign misalign   = resp_valid && r_mis;
  assign rdata      = (resp_valid && !r_store && !r_mis) ? load_ext(ram_q, r_size, r_lo, r_uns)
                                                         : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with WAIT_STATES=1.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  MemRead = 2'b00, MemWrite = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] Aluout = 32'h0, busB = 32'h0;
  logic        ready, stall, resp_valid, misalign;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic [32:0] exp_e;
  string       exp_n;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_unsigned(mem_unsigned), .Aluout(Aluout), .busB(busB),
    .ready(ready), .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Response monitor: pop the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp: rdata=%h misalign=%b", rdata, misalign);
        end else begin
          exp_e = exp_q.pop_front();
          exp_n = name_q.pop_front();
          if ({misalign, rdata} !== exp_e) begin
            bad++;
            $display("FAIL %s: got mis=%b rdata=%h want mis=%b rdata=%h",
                     exp_n, misalign, rdata, exp_e[32], exp_e[31:0]);
          end
        end
      end else if (rdata !== 32'h0 || misalign !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL idle_outputs: rdata=%h misalign=%b want 0", rdata, misalign);
      end
    end
  end

  // Issue one request, then check latency and stall until the response.
  task automatic do_req(input string nm, input logic [1:0] rd, input logic [1:0] wr,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat);
    int n;
    bit seen, stall_ok;
    @(negedge clk);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; mem_unsigned = uns;
    Aluout = addr; busB = data;
    exp_q.push_back({exp_mis, exp_rd});
    name_q.push_back(nm);
    @(posedge clk); #1;
    req_valid = 1'b0; MemRead = 2'b00; MemWrite = 2'b00;
    n = 0; seen = 0; stall_ok = 1;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (stall !== 1'b1) stall_ok = 0;
      if (resp_valid === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: no resp_valid within %0d cycles", nm, n);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
      end
    end else if (n != exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", nm, n, exp_lat);
    end
    total++;
    if (!stall_ok) begin
      bad++;
      $display("FAIL %s_stall: stall dropped before response", nm);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ready, stall, resp_valid, misalign, rdata} !== {4'b1000, 32'h0}) begin
      bad++;
      $display("FAIL reset_state: ready=%b stall=%b resp=%b mis=%b rdata=%h want 1 0 0 0 0",
               ready, stall, resp_valid, misalign, rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_word;
    do_req("st_word_10", 2'b00, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, WS+2);
    do_req("ld_word_10", 2'b11, 2'b00, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, WS+2);
  endtask

  task automatic test_byte;
    do_req("st_word_20", 2'b00, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, WS+2);
    do_req("st_byte_21", 2'b00, 2'b01, 1'b0, 32'h21, 32'hAB, 32'h0, 1'b0, WS+2);
    do_req("ld_sbyte_21", 2'b01, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAB, 1'b0, WS+2);
    do_req("ld_ubyte_21", 2'b01, 2'b00, 1'b1, 32'h21, 32'h0, 32'h000000AB, 1'b0, WS+2);
    do_req("ld_word_20a", 2'b11, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0000AB00, 1'b0, WS+2);
  endtask

  task automatic test_half;
    do_req("st_half_22", 2'b00, 2'b10, 1'b0, 32'h22, 32'h8001, 32'h0, 1'b0, WS+2);
    do_req("ld_shalf_22", 2'b10, 2'b00, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, WS+2);
    do_req("ld_uhalf_22", 2'b10, 2'b00, 1'b1, 32'h22, 32'h0, 32'h00008001, 1'b0, WS+2);
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req("ld_half_23", 2'b10, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1, 1);
    do_req("st_word_22", 2'b00, 2'b11, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
`else
    do_req("ld_half_23", 2'b10, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFF8001, 1'b0, WS+2);
`endif
    do_req("ld_word_20b", 2'b11, 2'b00, 1'b0, 32'h20, 32'h0, 32'h8001AB00, 1'b0, WS+2);
  endtask

  task automatic test_wrap;
    do_req("ld_wrap", 2'b11, 2'b00, 1'b0, DEPTH*4 + 32'h10, 32'h0, 32'h12345678, 1'b0, WS+2);
  endtask

  task automatic test_reset_mid;
    do_req("st_word_40", 2'b00, 2'b11, 1'b0, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, WS+2);
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 2'b11; MemRead = 2'b00; Aluout = 32'h40; busB = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0; MemWrite = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({ready, stall, resp_valid, misalign, rdata} !== {4'b1000, 32'h0}) begin
      bad++;
      $display("FAIL reset_mid: ready=%b stall=%b resp=%b mis=%b rdata=%h want 1 0 0 0 0",
               ready, stall, resp_valid, misalign, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    do_req("ld_word_40", 2'b11, 2'b00, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, WS+2);
  endtask

  task automatic test_both_and_none;
    do_req("st_word_08", 2'b00, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, WS+2);
    do_req("both_codes", 2'b11, 2'b01, 1'b0, 32'h8, 32'h55, 32'h0, 1'b0, WS+2);
    do_req("ld_word_08", 2'b11, 2'b00, 1'b0, 32'h8, 32'h0, 32'h00000055, 1'b0, WS+2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 1'b1; MemRead = 2'b00; MemWrite = 2'b00; Aluout = 32'h8;
      @(posedge clk); #1;
      total++;
      if (ready !== 1'b1 || stall !== 1'b0) begin
        bad++;
        $display("FAIL no_codes: ready=%b stall=%b want 1 0", ready, stall);
      end
    end
    req_valid = 1'b0;
    do_req("ld_word_08b", 2'b11, 2'b00, 1'b0, 32'h8, 32'h0, 32'h00000055, 1'b0, WS+2);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap();
    test_reset_mid();
    test_both_and_none();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
